// File: rtl/msrv32_csr_file.sv
// Machine-mode CSR file for a single-hart RV32 core: status/trap CSRs,
// interrupt enable/pending, and the 64-bit cycle and instret counters.
module msrv32_csr_file (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        wr_en_in,
  input  logic [11:0] csr_addr_in,
  input  logic [2:0]  csr_op_in,
  input  logic [31:0] rs1_in,
  input  logic [4:0]  imm_in,
  input  logic [31:0] pc_in,
  input  logic        trap_taken_in,
  input  logic [4:0]  trap_cause_in,
  input  logic [31:0] trap_val_in,
  input  logic        mret_in,
  input  logic        instret_inc_in,
  input  logic        sw_irq_in,
  input  logic        timer_irq_in,
  input  logic        ext_irq_in,
  output logic [31:0] csr_data_out,
  output logic        illegal_csr_out,
  output logic [31:0] trap_address_out,
  output logic [31:0] epc_out,
  output logic        mie_global_out,
  output logic        irq_pending_out
);

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [2:0]  mie_bits;     // {meie, mtie, msie}
  logic [2:0]  mip_bits;     // {meip, mtip, msip}
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  logic [31:0] rdata;
  logic        implemented;
  logic        writable;
  logic [31:0] operand;
  logic [31:0] wdata;
  logic        op_valid;
  logic        wr_fire;

  always_comb begin
    rdata       = 32'h0;
    implemented = 1'b1;
    writable    = 1'b0;
    case (csr_addr_in)
      CSR_MSTATUS: begin
        rdata    = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
        writable = 1'b1;
      end
      CSR_MISA:      rdata = 32'h4000_0100;
      CSR_MHARTID:   rdata = 32'h0;
      CSR_MIE: begin
        rdata    = {20'b0, mie_bits[2], 3'b0, mie_bits[1], 3'b0, mie_bits[0], 3'b0};
        writable = 1'b1;
      end
      CSR_MIP:       rdata = {20'b0, mip_bits[2], 3'b0, mip_bits[1], 3'b0, mip_bits[0], 3'b0};
      CSR_MTVEC:     begin rdata = mtvec;    writable = 1'b1; end
      CSR_MSCRATCH:  begin rdata = mscratch; writable = 1'b1; end
      CSR_MEPC:      begin rdata = mepc;     writable = 1'b1; end
      CSR_MCAUSE:    begin rdata = mcause;   writable = 1'b1; end
      CSR_MTVAL:     begin rdata = mtval;    writable = 1'b1; end
      CSR_MCYCLE:    begin rdata = mcycle[31:0];    writable = 1'b1; end
      CSR_MCYCLEH:   begin rdata = mcycle[63:32];   writable = 1'b1; end
      CSR_MINSTRET:  begin rdata = minstret[31:0];  writable = 1'b1; end
      CSR_MINSTRETH: begin rdata = minstret[63:32]; writable = 1'b1; end
      CSR_CYCLE:     rdata = mcycle[31:0];
      CSR_CYCLEH:    rdata = mcycle[63:32];
      CSR_INSTRET:   rdata = minstret[31:0];
      CSR_INSTRETH:  rdata = minstret[63:32];
      default:       implemented = 1'b0;
    endcase
  end

  assign csr_data_out    = rdata;
  assign illegal_csr_out = ~implemented | (wr_en_in & (csr_addr_in[11:10] == 2'b11));

  // Read-modify-write value is built from the pre-write read data.
  always_comb begin
    operand  = csr_op_in[2] ? {27'b0, imm_in} : rs1_in;
    op_valid = 1'b1;
    case (csr_op_in[1:0])
      2'b01:   wdata = operand;
      2'b10:   wdata = rdata | operand;
      2'b11:   wdata = rdata & ~operand;
      default: begin wdata = rdata; op_valid = 1'b0; end
    endcase
  end

  assign wr_fire = wr_en_in & writable & op_valid;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mepc         <= 32'h0;
      mcause       <= 32'h0;
      mtval        <= 32'h0;
    end else if (trap_taken_in) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
      mepc         <= pc_in & 32'hFFFF_FFFC;
      mcause       <= {trap_cause_in[4], 27'b0, trap_cause_in[3:0]};
      mtval        <= trap_val_in;
    end else begin
      if (mret_in) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (wr_fire && csr_addr_in == CSR_MSTATUS) begin
        mstatus_mie  <= wdata[3];
        mstatus_mpie <= wdata[7];
      end
      // mret touches only mstatus, so writes to the other trap CSRs proceed.
      if (wr_fire && csr_addr_in == CSR_MEPC)   mepc   <= wdata & 32'hFFFF_FFFC;
      if (wr_fire && csr_addr_in == CSR_MCAUSE) mcause <= wdata;
      if (wr_fire && csr_addr_in == CSR_MTVAL)  mtval  <= wdata;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mie_bits <= 3'b0;
      mip_bits <= 3'b0;
      mtvec    <= 32'h0;
      mscratch <= 32'h0;
    end else begin
      mip_bits <= {ext_irq_in, timer_irq_in, sw_irq_in};
      if (wr_fire && csr_addr_in == CSR_MIE)
        mie_bits <= {wdata[11], wdata[7], wdata[3]};
      // Reserved mode encodings 1x keep the previous mode; the base always updates.
      if (wr_fire && csr_addr_in == CSR_MTVEC)
        mtvec <= {wdata[31:2], wdata[1] ? mtvec[1:0] : wdata[1:0]};
      if (wr_fire && csr_addr_in == CSR_MSCRATCH)
        mscratch <= wdata;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mcycle   <= 64'h0;
      minstret <= 64'h0;
    end else begin
      if (wr_fire && csr_addr_in == CSR_MCYCLE)
        mcycle <= {mcycle[63:32], wdata};
      else if (wr_fire && csr_addr_in == CSR_MCYCLEH)
        mcycle <= {wdata, mcycle[31:0]};
      else
        mcycle <= mcycle + 64'd1;

      if (wr_fire && csr_addr_in == CSR_MINSTRET)
        minstret <= {minstret[63:32], wdata};
      else if (wr_fire && csr_addr_in == CSR_MINSTRETH)
        minstret <= {wdata, minstret[31:0]};
      else if (instret_inc_in)
        minstret <= minstret + 64'd1;
    end
  end

  always_comb begin
    trap_address_out = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == 2'b01 && trap_cause_in[4])
      trap_address_out = {mtvec[31:2], 2'b00} + {26'b0, trap_cause_in[3:0], 2'b00};
  end

  assign epc_out         = mepc;
  assign mie_global_out  = mstatus_mie;
  assign irq_pending_out = mstatus_mie & |(mie_bits & mip_bits);

endmodule

// File: tb/tb_msrv32_csr_file.sv
// Bench for msrv32_csr_file: a behavioural CSR model checked every cycle,
// directed scenarios pinned with literal values, then randomized traffic.
module tb_msrv32_csr_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en;
  logic [11:0] csr_addr;
  logic [2:0]  csr_op;
  logic [31:0] rs1;
  logic [4:0]  imm;
  logic [31:0] pc;
  logic        trap_taken;
  logic [4:0]  trap_cause;
  logic [31:0] trap_val;
  logic        mret;
  logic        instret_inc;
  logic        sw_irq, timer_irq, ext_irq;
  logic [31:0] csr_data;
  logic        illegal_csr;
  logic [31:0] trap_address;
  logic [31:0] epc;
  logic        mie_global;
  logic        irq_pending;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;
  logic [31:0] exp_q[$];

  msrv32_csr_file dut (
    .clk_in(clk), .rst_in(rst), .wr_en_in(wr_en), .csr_addr_in(csr_addr),
    .csr_op_in(csr_op), .rs1_in(rs1), .imm_in(imm), .pc_in(pc),
    .trap_taken_in(trap_taken), .trap_cause_in(trap_cause), .trap_val_in(trap_val),
    .mret_in(mret), .instret_inc_in(instret_inc), .sw_irq_in(sw_irq),
    .timer_irq_in(timer_irq), .ext_irq_in(ext_irq), .csr_data_out(csr_data),
    .illegal_csr_out(illegal_csr), .trap_address_out(trap_address), .epc_out(epc),
    .mie_global_out(mie_global), .irq_pending_out(irq_pending)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_mstatus, m_mie, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;

  function automatic logic m_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
      12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
      12'hC82, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_writable(input logic [11:0] a);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
      12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus | 32'h0000_1800;
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip;
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_trap_addr();
    logic [31:0] base;
    base = m_mtvec & 32'hFFFF_FFFC;
    if (m_mtvec[1:0] == 2'b01 && trap_cause[4])
      return base + 32'(trap_cause[3:0]) * 4;
    return base;
  endfunction

  always @(posedge clk or posedge rst) begin : model_update
    logic [31:0] old_v, opnd, nv, n_mstatus, n_mepc, n_mcause, n_mtval;
    logic [63:0] n_cyc, n_ins;
    if (rst) begin
      m_mstatus = 0; m_mie = 0; m_mip = 0; m_mtvec = 0;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
      m_cycle = 0; m_instret = 0;
    end else begin
      old_v = m_read(csr_addr);
      opnd  = csr_op[2] ? 32'(imm) : rs1;
      case (csr_op[1:0])
        2'd1:    nv = opnd;
        2'd2:    nv = old_v | opnd;
        2'd3:    nv = old_v & ~opnd;
        default: nv = old_v;
      endcase
      n_cyc = m_cycle + 64'd1;
      n_ins = m_instret + (instret_inc ? 64'd1 : 64'd0);
      n_mstatus = m_mstatus; n_mepc = m_mepc; n_mcause = m_mcause; n_mtval = m_mtval;
      if (wr_en && csr_op[1:0] != 2'd0 && m_writable(csr_addr)) begin
        case (csr_addr)
          12'h300: n_mstatus = nv & 32'h0000_0088;
          12'h304: m_mie = nv & 32'h0000_0888;
          12'h305: m_mtvec = nv[1] ? ((nv & 32'hFFFF_FFFC) | (m_mtvec & 32'h3)) : nv;
          12'h340: m_mscratch = nv;
          12'h341: n_mepc = nv & 32'hFFFF_FFFC;
          12'h342: n_mcause = nv;
          12'h343: n_mtval = nv;
          12'hB00: n_cyc = {m_cycle[63:32], nv};
          12'hB80: n_cyc = {nv, m_cycle[31:0]};
          12'hB02: n_ins = {m_instret[63:32], nv};
          12'hB82: n_ins = {nv, m_instret[31:0]};
          default: ;
        endcase
      end
      if (trap_taken) begin
        n_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
        n_mepc    = pc & 32'hFFFF_FFFC;
        n_mcause  = (trap_cause[4] ? 32'h8000_0000 : 32'h0) + 32'(trap_cause[3:0]);
        n_mtval   = trap_val;
      end else if (mret) begin
        n_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
      end
      m_mstatus = n_mstatus; m_mepc = n_mepc; m_mcause = n_mcause; m_mtval = n_mtval;
      m_cycle = n_cyc; m_instret = n_ins;
      m_mip = (ext_irq ? 32'h800 : 32'h0) | (timer_irq ? 32'h80 : 32'h0) | (sw_irq ? 32'h8 : 32'h0);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    cmp(name, act, e);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("csr_data", csr_data, m_read(csr_addr));
      cmp("illegal", {31'b0, illegal_csr},
          {31'b0, !m_impl(csr_addr) || (wr_en && csr_addr[11:10] == 2'b11)});
      cmp("trap_addr", trap_address, m_trap_addr());
      cmp("epc", epc, m_mepc);
      cmp("mie_global", {31'b0, mie_global}, {31'b0, m_mstatus[3]});
      cmp("irq_pending", {31'b0, irq_pending}, {31'b0, m_mstatus[3] && ((m_mie & m_mip) != 0)});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    wr_en = 0; csr_op = 0; rs1 = 0; imm = 0; pc = 0; trap_taken = 0;
    trap_cause = 0; trap_val = 0; mret = 0; instret_inc = 0;
    sw_irq = 0; timer_irq = 0; ext_irq = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [2:0] op,
                        input logic [31:0] r, input logic [4:0] i);
    wr_en = 1; csr_addr = a; csr_op = op; rs1 = r; imm = i;
  endtask

  logic [11:0] addrs [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                              12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                              12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14,
                              12'h7C0, 12'hB01};

  initial begin
    idle();
    csr_addr = 12'h300;
    #1 rst = 1;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // reset state
    @(negedge clk);
    lit("rst_mstatus", csr_data, 32'h0000_1800);
    lit("rst_epc", epc, 32'h0);
    lit("rst_mie", {31'b0, mie_global}, 32'h0);
    lit("rst_irq", {31'b0, irq_pending}, 32'h0);
    lit("rst_trap_addr", trap_address, 32'h0);
    next_cycle();

    // RW / RSI / RC on mscratch
    csr_wr(12'h340, 3'b001, 32'hDEAD_BEEF, 5'h0); next_cycle();
    csr_wr(12'h340, 3'b110, 32'h0, 5'h10);
    @(negedge clk); lit("rw_mscratch", csr_data, 32'hDEAD_BEEF); next_cycle();
    csr_wr(12'h340, 3'b011, 32'h0000_000F, 5'h0);
    @(negedge clk); lit("rsi_mscratch", csr_data, 32'hDEAD_BEFF); next_cycle();
    idle(); csr_addr = 12'h340;
    @(negedge clk); lit("rc_mscratch", csr_data, 32'hDEAD_BEF0); next_cycle();

    // illegal accesses
    csr_wr(12'hC00, 3'b001, 32'h0, 5'h0);
    @(negedge clk); lit("wr_cycle_illegal", {31'b0, illegal_csr}, 32'h1); next_cycle();
    idle(); csr_addr = 12'h7C0;
    @(negedge clk); lit("rd_7c0_illegal", {31'b0, illegal_csr}, 32'h1); next_cycle();

    // trap then mret
    csr_wr(12'h300, 3'b001, 32'h8, 5'h0); next_cycle();
    idle(); csr_addr = 12'h300;
    trap_taken = 1; pc = 32'h103; trap_cause = 5'h02; trap_val = 32'h55;
    next_cycle();
    idle(); csr_addr = 12'h300; mret = 1;
    @(negedge clk);
    lit("trap_mstatus", csr_data, 32'h0000_1880);
    lit("trap_epc", epc, 32'h100);
    lit("trap_mie", {31'b0, mie_global}, 32'h0);
    next_cycle();
    idle(); csr_addr = 12'h342;
    @(negedge clk);
    lit("trap_mcause", csr_data, 32'h2);
    lit("mret_mie", {31'b0, mie_global}, 32'h1);
    next_cycle();

    // mtvec vectoring and reserved mode
    csr_wr(12'h305, 3'b001, 32'h1001, 5'h0); next_cycle();
    idle(); csr_addr = 12'h305; trap_cause = 5'h17;
    @(negedge clk); lit("vec_irq", trap_address, 32'h101C); next_cycle();
    trap_cause = 5'h07;
    @(negedge clk); lit("vec_exc", trap_address, 32'h1000); next_cycle();
    csr_wr(12'h305, 3'b001, 32'h2003, 5'h0); next_cycle();
    idle(); csr_addr = 12'h305;
    @(negedge clk); lit("mtvec_bad_mode", csr_data, 32'h2001); next_cycle();

    // mcycle carry
    csr_wr(12'hB00, 3'b001, 32'hFFFF_FFFF, 5'h0); next_cycle();
    idle(); csr_addr = 12'hB00;
    @(negedge clk); lit("mcycle_lo_max", csr_data, 32'hFFFF_FFFF); next_cycle();
    @(negedge clk); lit("mcycle_lo_wrap", csr_data, 32'h0); next_cycle();
    csr_addr = 12'hB80;
    @(negedge clk); lit("mcycle_hi_carry", csr_data, 32'h1); next_cycle();

    // trap and mret together: trap wins
    idle(); csr_addr = 12'h300;
    trap_taken = 1; mret = 1; pc = 32'h204; trap_cause = 5'h0B;
    next_cycle();
    idle(); csr_addr = 12'h300;
    @(negedge clk);
    lit("trap_mret_mstatus", csr_data, 32'h0000_1880);
    lit("trap_mret_epc", epc, 32'h204);
    next_cycle();

    // timer interrupt pending latency
    csr_wr(12'h304, 3'b001, 32'h80, 5'h0); next_cycle();
    csr_wr(12'h300, 3'b110, 32'h0, 5'h08); next_cycle();
    idle(); csr_addr = 12'h344; timer_irq = 1;
    @(negedge clk); lit("irq_not_yet", {31'b0, irq_pending}, 32'h0); next_cycle();
    @(negedge clk);
    lit("irq_pending", {31'b0, irq_pending}, 32'h1);
    lit("mip_timer", csr_data, 32'h80);
    next_cycle();

    // asynchronous reset mid-cycle
    csr_addr = 12'h300; trap_cause = 5'h0;
    rst = 1; #1;
    lit("arst_mstatus", csr_data, 32'h0000_1800);
    lit("arst_epc", epc, 32'h0);
    lit("arst_mie", {31'b0, mie_global}, 32'h0);
    lit("arst_irq", {31'b0, irq_pending}, 32'h0);
    lit("arst_trap_addr", trap_address, 32'h0);
    next_cycle();
    rst = 0; idle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      wr_en       = ($urandom_range(0, 3) != 0);
      csr_addr    = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 19)];
      csr_op      = 3'($urandom_range(0, 7));
      rs1         = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      imm         = 5'($urandom);
      pc          = $urandom;
      trap_taken  = ($urandom_range(0, 9) == 0);
      trap_cause  = 5'($urandom);
      trap_val    = $urandom;
      mret        = ($urandom_range(0, 7) == 0);
      instret_inc = 1'($urandom);
      sw_irq      = 1'($urandom);
      timer_irq   = 1'($urandom);
      ext_irq     = 1'($urandom);
      rst         = ($urandom_range(0, 299) == 0);
      next_cycle();
    end
    rst = 0; idle();
    next_cycle();

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
